// File: rtl/btn_pkg.sv
// Shared types and constants for the button input controller: debounce
// FSM state encoding, counter width and status word field offsets.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } btn_state_e;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned STAT_LEVEL_OFS = 0;
  localparam int unsigned STAT_PRESS_OFS = 8;
  localparam int unsigned STAT_OVF_OFS   = 16;
  localparam int unsigned STAT_REL_OFS   = 24;

endpackage

// File: rtl/btn_debounce.sv
// Single-button two-flop synchroniser and debounce FSM; emits the debounced
// level plus one-cycle press and release event pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // The target state is entered on the edge where the count would reach
  // DEBOUNCE_CYCLES, so a clean input edge lands DEBOUNCE_CYCLES+2 edges later.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        if (sync2_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_LOW;
        end else if (cnt_q >= LAST_CNT) begin
          state_d = ST_HIGH;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (sync2_q) begin
          state_d = ST_HIGH;
        end else if (cnt_q >= LAST_CNT) begin
          state_d = ST_LOW;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  assign level_o   = (state_q == ST_HIGH) || (state_q == ST_WAIT_LOW);
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/button_input_ctrl.sv
// Debounced button inputs with sticky press/overflow flags and a 32-bit
// status word. Define BTN_RELEASE_EVT_EN to add sticky release flags.
module button_input_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               clr,
  input  logic [7:0]         clr_mask,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [31:0]        status
);

  logic [NUM_BTN-1:0] rel_evt;
  logic [NUM_BTN-1:0] clr_sel;
  logic [NUM_BTN-1:0] press_flag_q, press_flag_d;
  logic [NUM_BTN-1:0] ovf_flag_q, ovf_flag_d;
  logic               unused_clr_mask;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i    (clock),
      .rst_i    (reset),
      .raw_i    (btn_raw[g]),
      .level_o  (level[g]),
      .press_o  (press_pulse[g]),
      .release_o(rel_evt[g])
    );
  end

  // Mask bits above NUM_BTN select nothing.
  assign clr_sel         = clr ? clr_mask[NUM_BTN-1:0] : '0;
  assign unused_clr_mask = ^clr_mask;

  // A coincident press wins over clear for press_flag; overflow is cleared.
  assign press_flag_d = press_pulse | (press_flag_q & ~clr_sel);
  assign ovf_flag_d   = ~clr_sel & (ovf_flag_q | (press_pulse & press_flag_q));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_flag_q <= '0;
      ovf_flag_q   <= '0;
    end else begin
      press_flag_q <= press_flag_d;
      ovf_flag_q   <= ovf_flag_d;
    end
  end

`ifdef BTN_RELEASE_EVT_EN
  logic [NUM_BTN-1:0] rel_flag_q, rel_flag_d;

  assign rel_flag_d = rel_evt | (rel_flag_q & ~clr_sel);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rel_flag_q <= '0;
    end else begin
      rel_flag_q <= rel_flag_d;
    end
  end
`else
  logic unused_rel_evt;
  assign unused_rel_evt = ^rel_evt;
`endif

  always_comb begin
    status = '0;
    status[STAT_LEVEL_OFS +: NUM_BTN] = level;
    status[STAT_PRESS_OFS +: NUM_BTN] = press_flag_q;
    status[STAT_OVF_OFS   +: NUM_BTN] = ovf_flag_q;
`ifdef BTN_RELEASE_EVT_EN
    status[STAT_REL_OFS   +: NUM_BTN] = rel_flag_q;
`endif
  end

endmodule
